// File: rtl/conv_pkg.sv
// ============================================================================
// Module : conv_pkg
// Brief  : Shared convolution geometry constants and FSM state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int IFM_DATA_WIDTH = 32;
    localparam int NUM_LAYERS     = 32;
    localparam int NUM_FILTERS    = 64;
    localparam int NUM_ROWS       = 20;
    localparam int ROW_STEP       = 3;
    localparam int TAPS           = 3;

    // 3-tap windows stepping by ROW_STEP across NUM_ROWS rows -> 6 positions
    localparam int NUM_ROW_STEPS  = (NUM_ROWS - TAPS) / ROW_STEP + 1;
    localparam int TOTAL_GROUPS   = NUM_LAYERS * NUM_ROW_STEPS * NUM_FILTERS;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [1:0] TAP_LAST = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ifm_window_collector_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with flush; a push into a full FIFO succeeds
//          only when a pop happens in the same cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/ifm_window_collector.sv
// ============================================================================
// Module : ifm_window_collector
// Brief  : Aligns BRAM read data to its address, packs 3-word windows into a
//          FIFO and hands them to the PE until the run's window count is met.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifm_window_collector #(
    parameter int DATA_WIDTH   = conv_pkg::IFM_DATA_WIDTH,
    parameter int RD_LATENCY   = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int TOTAL_GROUPS = conv_pkg::TOTAL_GROUPS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    addr_valid,
    input  logic [DATA_WIDTH-1:0]   bram_rdata,
    output logic [3*DATA_WIDTH-1:0] win_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done
);

    import conv_pkg::*;

    localparam int CNT_W  = $clog2(TOTAL_GROUPS + 1);
    localparam int WIN_W  = 3 * DATA_WIDTH;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                 state_q, state_d;
    logic [RD_LATENCY-1:0]  pipe_q, pipe_d, pipe_shift;
    logic [1:0]             tap_idx_q, tap_idx_d;
    logic [DATA_WIDTH-1:0]  tap0_q, tap0_d, tap1_q, tap1_d;
    logic [CNT_W-1:0]       pop_cnt_q, pop_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   capture, push, pop, flush, fifo_full;
    logic [FCNT_W-1:0]      fifo_cnt;
    logic [WIN_W-1:0]       fifo_head;

    generate
        if (RD_LATENCY == 1) begin : g_pipe_single
            assign pipe_shift = addr_valid;
        end else begin : g_pipe_multi
            assign pipe_shift = {pipe_q[RD_LATENCY-2:0], addr_valid};
        end
    endgenerate

    assign pipe_d    = start ? '0 : pipe_shift;
    assign capture   = pipe_q[RD_LATENCY-1] && (state_q == ST_RUN) && !start;
    assign push      = capture && (tap_idx_q == TAP_LAST);
    assign win_valid = (state_q == ST_RUN) && (fifo_cnt != '0);
    assign pop       = win_valid && win_ready;
    assign win_data  = win_valid ? fifo_head : '0;
    assign flush     = start || ((state_q == ST_RUN) && (state_d == ST_DONE));

    always_comb begin
        tap_idx_d  = tap_idx_q;
        tap0_d     = tap0_q;
        tap1_d     = tap1_q;
        pop_cnt_d  = pop_cnt_q;
        overflow_d = overflow_q;
        if (start) begin
            tap_idx_d  = 2'd0;
            tap0_d     = '0;
            tap1_d     = '0;
            pop_cnt_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (capture) begin
                case (tap_idx_q)
                    2'd0: begin
                        tap0_d    = bram_rdata;
                        tap_idx_d = 2'd1;
                    end
                    2'd1: begin
                        tap1_d    = bram_rdata;
                        tap_idx_d = 2'd2;
                    end
                    default: begin
                        tap_idx_d = 2'd0;
                        // A same-cycle pop frees the slot, so only a stalled full FIFO drops
                        if (fifo_full && !pop) overflow_d = 1'b1;
                    end
                endcase
            end
            if (pop && (pop_cnt_q != CNT_W'(TOTAL_GROUPS))) pop_cnt_d = pop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pipe_q     <= '0;
            tap_idx_q  <= 2'd0;
            tap0_q     <= '0;
            tap1_q     <= '0;
            pop_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pipe_q     <= pipe_d;
            tap_idx_q  <= tap_idx_d;
            tap0_q     <= tap0_d;
            tap1_q     <= tap1_d;
            pop_cnt_q  <= pop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN:  if (pop_cnt_d == CNT_W'(TOTAL_GROUPS)) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == ST_RUN);
        done     = (state_q == ST_DONE);
        overflow = overflow_q;
    end

    sync_fifo #(
        .WIDTH (WIN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({bram_rdata, tap1_q, tap0_q}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_ifm_window_collector.sv
// ============================================================================
// Module : tb_ifm_window_collector
// Brief  : Directed checks of ifm_window_collector at read latencies 1 and 3.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ifm_window_collector;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_start, a_av, a_rdy;
    logic [31:0] a_rd;
    logic [95:0] a_wd;
    logic        a_wv, a_ov, a_busy, a_done;

    logic        b_start, b_av, b_rdy;
    logic [31:0] b_rd;
    logic [95:0] b_wd;
    logic        b_wv, b_ov, b_busy, b_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifm_window_collector #(
        .DATA_WIDTH(32), .RD_LATENCY(1), .FIFO_DEPTH(4), .TOTAL_GROUPS(6)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .addr_valid(a_av),
        .bram_rdata(a_rd), .win_data(a_wd), .win_valid(a_wv), .win_ready(a_rdy),
        .overflow(a_ov), .busy(a_busy), .done(a_done)
    );

    ifm_window_collector #(
        .DATA_WIDTH(32), .RD_LATENCY(3), .FIFO_DEPTH(4), .TOTAL_GROUPS(6)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .addr_valid(b_av),
        .bram_rdata(b_rd), .win_data(b_wd), .win_valid(b_wv), .win_ready(b_rdy),
        .overflow(b_ov), .busy(b_busy), .done(b_done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wrd(input int g, input int k);
        return 32'(g * 256 + k);
    endfunction

    function automatic logic [95:0] grp(input int g);
        return {wrd(g, 3), wrd(g, 2), wrd(g, 1)};
    endfunction

    task automatic start_a();
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
    endtask

    // Latency 1: data sits on the bus in the cycle after the address strobe
    task automatic send_a(input logic [31:0] d);
        a_av = 1'b1;
        cyc();
        a_av = 1'b0;
        a_rd = d;
        cyc();
        a_rd = 32'hDEAD_BEEF;
    endtask

    task automatic group_a(input int g);
        send_a(wrd(g, 1));
        send_a(wrd(g, 2));
        send_a(wrd(g, 3));
    endtask

    // Latency 3: garbage on the bus except exactly 3 cycles after the strobe
    task automatic send_b(input logic [31:0] d);
        b_av = 1'b1;
        cyc();
        b_av = 1'b0;
        b_rd = 32'hBAD0_0001;
        cyc();
        b_rd = 32'hBAD0_0002;
        cyc();
        b_rd = d;
        cyc();
        b_rd = 32'hBAD0_0003;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_av = 1'b0; a_rdy = 1'b0; a_rd = '0;
        b_start = 1'b0; b_av = 1'b0; b_rdy = 1'b0; b_rd = '0;
        repeat (3) cyc();

        chk("rst_win_valid", a_wv, 0);
        chk("rst_win_data", a_wd, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_overflow", a_ov, 0);
        chk("rst_busy_b", b_busy, 0);

        rst_n = 1'b1;
        cyc();

        // Read latency 3 on instance b
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        chk("lat_busy", b_busy, 1);
        b_rdy = 1'b1;
        send_b(32'h11);
        cyc();
        send_b(32'h22);
        chk("lat_no_early_valid", b_wv, 0);
        cyc();
        send_b(32'h33);
        chk("lat_valid", b_wv, 1);
        chk("lat_window", b_wd, {32'h33, 32'h22, 32'h11});
        cyc();
        chk("lat_valid_one_cycle", b_wv, 0);
        chk("lat_overflow", b_ov, 0);

        // Basic pack, latency 1
        start_a();
        chk("basic_busy", a_busy, 1);
        a_rdy = 1'b1;
        send_a(32'h11);
        cyc(); cyc();
        send_a(32'h22);
        cyc(); cyc();
        chk("basic_no_early_valid", a_wv, 0);
        send_a(32'h33);
        chk("basic_valid", a_wv, 1);
        chk("basic_window", a_wd, {32'h33, 32'h22, 32'h11});
        cyc();
        chk("basic_valid_one_cycle", a_wv, 0);
        chk("basic_overflow", a_ov, 0);

        // Backpressure: 5 groups into a 4-deep FIFO
        start_a();
        a_rdy = 1'b0;
        for (int g = 1; g <= 4; g++) group_a(g);
        chk("bp_valid_full", a_wv, 1);
        chk("bp_head_full", a_wd, grp(1));
        chk("bp_no_overflow_yet", a_ov, 0);
        group_a(5);
        chk("bp_overflow", a_ov, 1);
        a_rdy = 1'b1;
        for (int g = 1; g <= 4; g++) begin
            chk($sformatf("bp_drain_g%0d", g), a_wd, grp(g));
            cyc();
        end
        chk("bp_empty_after_drain", a_wv, 0);
        chk("bp_overflow_sticky", a_ov, 1);
        a_rdy = 1'b0;

        // Full FIFO with a pop in the same cycle as the 3rd word
        start_a();
        chk("fp_overflow_cleared", a_ov, 0);
        for (int g = 1; g <= 4; g++) group_a(g);
        send_a(wrd(5, 1));
        send_a(wrd(5, 2));
        a_av = 1'b1;
        cyc();
        a_av = 1'b0;
        a_rd = wrd(5, 3);
        a_rdy = 1'b1;
        cyc();
        a_rdy = 1'b0;
        a_rd = 32'hDEAD_BEEF;
        chk("fp_no_overflow", a_ov, 0);
        chk("fp_head_after_pop", a_wd, grp(2));
        a_rdy = 1'b1;
        for (int g = 2; g <= 5; g++) begin
            chk($sformatf("fp_drain_g%0d", g), a_wd, grp(g));
            cyc();
        end
        chk("fp_empty_after_drain", a_wv, 0);

        // Completion after 6 popped windows
        start_a();
        for (int g = 1; g <= 5; g++) group_a(g);
        group_a(6);
        chk("done_last_valid", a_wv, 1);
        chk("done_not_yet", a_done, 0);
        cyc();
        chk("done_set", a_done, 1);
        chk("done_busy_low", a_busy, 0);
        group_a(7);
        chk("done_no_valid", a_wv, 0);
        cyc();
        chk("done_no_valid_later", a_wv, 0);
        chk("done_sticky", a_done, 1);
        start_a();
        chk("restart_done_clear", a_done, 0);
        chk("restart_busy", a_busy, 1);
        group_a(8);
        chk("restart_valid", a_wv, 1);
        chk("restart_window", a_wd, grp(8));

        // Async reset between the 1st and 2nd word of a group
        cyc();
        start_a();
        send_a(32'hAA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_valid", a_wv, 0);
        chk("arst_data", a_wd, 0);
        chk("arst_done", a_done, 0);
        #2;
        rst_n = 1'b1;
        cyc();
        start_a();
        send_a(32'h01);
        send_a(32'h02);
        send_a(32'h03);
        chk("arst_fresh_valid", a_wv, 1);
        chk("arst_fresh_window", a_wd, {32'h03, 32'h02, 32'h01});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
